wr_ptr_ctrl: RTL and testbench

Write-domain pointer and flag controller for the dual-clock FIFO. It owns the write pointer and gates memory writes from `wr_en`. It produces the binary RAM address and the Gray-coded pointer that the synchroniser carries to the read domain. It also compares the write pointer against the synchronised read pointer to drive `full`, `almost_full`, fill level and overflow signalling.

---
 rtl/wr_ptr_ctrl.sv | 93 +++++++++
 tb/tb_wr_ptr_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wr_ptr_ctrl.sv
// ============================================================================
// Module   : wr_ptr_ctrl
// Brief    : Write-domain pointer and flag controller for a dual-clock FIFO.
//            Optional sticky overflow flag is built when WR_OVF_STICKY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_ptr_ctrl #(
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int AFULL_TH = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW:0]   rd_ptr_gray_sync,
  output logic          mem_we,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   wr_ptr_gray,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wr_level,
`ifdef WR_OVF_STICKY_EN
  input  logic          ovf_clr,
  output logic          ovf_sticky,
`endif
  output logic          overflow
);

  localparam int            PW         = AW + 1;
  localparam logic [PW-1:0] C_AFULL_TH = PW'(AFULL_TH);

  logic [PW-1:0] r_wbin;
  logic          w_inc;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_full_gray;
  logic [PW-1:0] w_level_next;

  assign w_inc        = wr_en & ~full;
  assign mem_we       = w_inc;
  assign w_wbin_next  = r_wbin + {{(PW-1){1'b0}}, w_inc};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  assign wr_addr      = r_wbin[AW-1:0];

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign w_full_gray  = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};
  assign w_level_next = w_wbin_next - w_rbin;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_rbin[i] = ^(rd_ptr_gray_sync >> i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      wr_ptr_gray <= w_wgray_next;
      full        <= (w_wgray_next == w_full_gray);
      almost_full <= (w_level_next >= C_AFULL_TH);
      wr_level    <= w_level_next;
      overflow    <= wr_en & full;
    end
  end

`ifdef WR_OVF_STICKY_EN
  // Clear takes priority over a same-cycle overflow event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end else if (wr_en & full) begin
      ovf_sticky <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wr_ptr_ctrl.sv
// ============================================================================
// Module   : tb_wr_ptr_ctrl
// Brief    : Directed self-checking bench for wr_ptr_ctrl (DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wr_ptr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] rd_ptr_gray_sync;
  logic       mem_we;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;
`ifdef WR_OVF_STICKY_EN
  logic       ovf_clr;
  logic       ovf_sticky;
`endif

  int n_vec;
  int n_err;

  wr_ptr_ctrl #(.DEPTH(8), .AW(3), .AFULL_TH(6)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .mem_we           (mem_we),
    .wr_addr          (wr_addr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .almost_full      (almost_full),
    .wr_level         (wr_level),
`ifdef WR_OVF_STICKY_EN
    .ovf_clr          (ovf_clr),
    .ovf_sticky       (ovf_sticky),
`endif
    .overflow         (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(wr_addr),     32'h0);
    check({tag, "_gray"},  32'(wr_ptr_gray), 32'h0);
    check({tag, "_full"},  32'(full),        32'h0);
    check({tag, "_afull"}, 32'(almost_full), 32'h0);
    check({tag, "_level"}, 32'(wr_level),    32'h0);
    check({tag, "_ovf"},   32'(overflow),    32'h0);
  endtask

  logic [3:0] gray_tab [8];
  logic [3:0] b_cur;
  logic [3:0] b_prev;
  logic [3:0] b_exp;
  logic [3:0] g_exp;

  initial begin
    gray_tab[0] = 4'b0001; gray_tab[1] = 4'b0011; gray_tab[2] = 4'b0010; gray_tab[3] = 4'b0110;
    gray_tab[4] = 4'b0111; gray_tab[5] = 4'b0101; gray_tab[6] = 4'b0100; gray_tab[7] = 4'b1100;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    wr_en = 1'b1;
    rd_ptr_gray_sync = 4'b0000;
`ifdef WR_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif

    // Reset held with wr_en high
    step();
    step();
    check_all_zero("rst");

    // Release and fill eight entries against an empty read pointer
    rst_n = 1'b1;
    #1;
    check("first_mem_we", 32'(mem_we), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      check("fill_mem_we", 32'(mem_we), 32'h1);
      step();
      check("fill_gray",  32'(wr_ptr_gray), 32'(gray_tab[i-1]));
      check("fill_addr",  32'(wr_addr),     32'(i % 8));
      check("fill_level", 32'(wr_level),    32'(i));
      check("fill_afull", 32'(almost_full), 32'(i >= 6));
      check("fill_full",  32'(full),        32'(i == 8));
    end

    // Three rejected writes while full
    for (int i = 0; i < 3; i++) begin
      check("ovf_mem_we", 32'(mem_we), 32'h0);
      step();
      check("ovf_pulse", 32'(overflow),    32'h1);
      check("ovf_gray",  32'(wr_ptr_gray), 32'hC);
      check("ovf_addr",  32'(wr_addr),     32'h0);
      check("ovf_level", 32'(wr_level),    32'h8);
      check("ovf_full",  32'(full),        32'h1);
`ifdef WR_OVF_STICKY_EN
      check("ovf_sticky", 32'(ovf_sticky), 32'h1);
`endif
    end
    wr_en = 1'b0;
    step();
    check("ovf_end", 32'(overflow), 32'h0);
`ifdef WR_OVF_STICKY_EN
    check("sticky_hold", 32'(ovf_sticky), 32'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("sticky_clr", 32'(ovf_sticky), 32'h0);
`endif

    // Read side frees one entry
    rd_ptr_gray_sync = 4'b0001;
    step();
    check("rel_full",  32'(full),        32'h0);
    check("rel_level", 32'(wr_level),    32'h7);
    check("rel_afull", 32'(almost_full), 32'h1);
    wr_en = 1'b1;
    #1;
    check("rel_mem_we", 32'(mem_we),  32'h1);
    check("rel_addr",   32'(wr_addr), 32'h0);
    step();
    wr_en = 1'b0;
    check("rel_gray2",  32'(wr_ptr_gray), 32'hD);
    check("rel_addr2",  32'(wr_addr),     32'h1);
    check("rel_full2",  32'(full),        32'h1);
    check("rel_level2", 32'(wr_level),    32'h8);

    // Fresh start, then wrap with the read pointer trailing one write behind
    rst_n = 1'b0;
    rd_ptr_gray_sync = 4'b0000;
    #1;
    check_all_zero("rst2");
    rst_n = 1'b1;
    wr_en = 1'b1;
    b_cur  = 4'h0;
    b_prev = 4'h0;
    for (int k = 0; k < 20; k++) begin
      rd_ptr_gray_sync = b_prev ^ (b_prev >> 1);
      step();
      b_prev = b_cur;
      b_cur  = b_cur + 4'h1;
      check("wrap_gray",  32'(wr_ptr_gray), 32'(b_cur ^ (b_cur >> 1)));
      check("wrap_addr",  32'(wr_addr),     32'(b_cur[2:0]));
      check("wrap_level", 32'(wr_level),    (k == 0) ? 32'h1 : 32'h2);
      check("wrap_full",  32'(full),        32'h0);
    end
    b_exp = 4'h4;
    g_exp = 4'h6;
    check("wrap_end_bin",  32'(b_cur),       32'(b_exp));
    check("wrap_end_gray", 32'(wr_ptr_gray), 32'(g_exp));

    // Mid-operation asynchronous reset at level 5
    wr_en = 1'b0;
    rst_n = 1'b0;
    rd_ptr_gray_sync = 4'b0000;
    #1;
    rst_n = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    wr_en = 1'b0;
    check("mid_level", 32'(wr_level), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    #1;
    rst_n = 1'b1;
    wr_en = 1'b1;
    #1;
    check("mid_mem_we", 32'(mem_we),  32'h1);
    check("mid_addr0",  32'(wr_addr), 32'h0);
    step();
    wr_en = 1'b0;
    check("mid_addr1", 32'(wr_addr),     32'h1);
    check("mid_gray1", 32'(wr_ptr_gray), 32'h1);
    check("mid_lvl1",  32'(wr_level),    32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
